uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers, e.g. the pulse counter plus a status or echo source.
- Each producer issues a single-cycle new-data strobe with a byte. The arbiter buffers one byte per producer, picks a winner round-robin and issues a one-cycle start pulse with the byte to the TX core.
- It then tracks the TX busy handshake until the frame completes, flagging lost bytes and TX cores that never acknowledge.

Parameters:
- DATAWIDTH_BUS, 8: byte width per requester and on the TX data output.
- NUM_REQ, 2: number of requesters; legal range 2..8.
- REQ_IDX_SIZE, 3: width of the round-robin pointer and granted index; must satisfy 2^REQ_IDX_SIZE >= NUM_REQ.
- ACK_TIMEOUT, 16: number of cycles allowed in WAIT_ACK for txBusy to rise; legal range >= 2.

Ports:
- UART_TX_ARBITER_CLOCK_50  in  1  system clock, rising edge.
- UART_TX_ARBITER_RESET_InHigh  in  1  asynchronous, active-high reset.
- UART_TX_ARBITER_newData_InHigh  in  NUM_REQ  per-requester one-cycle strobe; bit i qualifies byte i.
- UART_TX_ARBITER_data_In  in  NUM_REQ*DATAWIDTH_BUS  flattened bytes; requester i occupies bits [i*DATAWIDTH_BUS +: DATAWIDTH_BUS].
- UART_TX_ARBITER_txBusy_InHigh  in  1  busy flag from the UART TX core.
- UART_TX_ARBITER_clearFlags_InHigh  in  1  synchronous clear of the sticky error flags.
- UART_TX_ARBITER_txStart_Out  out  1  one-cycle start pulse to the TX core.
- UART_TX_ARBITER_txData_Out  out  DATAWIDTH_BUS  byte presented to the TX core.
- UART_TX_ARBITER_grant_Out  out  NUM_REQ  one-hot owner of the current or most recent frame.
- UART_TX_ARBITER_pending_Out  out  NUM_REQ  per-requester "byte buffered, not yet granted".
- UART_TX_ARBITER_overrun_Out  out  NUM_REQ  sticky: a buffered byte was overwritten before it was granted.
- UART_TX_ARBITER_timeout_Out  out  1  sticky: the TX core did not acknowledge a start pulse.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE, round-robin pointer to 0.
  - All holding registers, pending, grant, overrun, timeout, txData_Out and txStart_Out go to 0.
  - A frame in flight is abandoned and buffered bytes are lost.
- Capture, every cycle and in every state:
  - When newData[i]=1, holding[i] <= byte i and pending[i] <= 1.
  - If pending[i] was already 1 and is not being granted this cycle: the latest byte wins and overrun[i] <= 1.
  - If a strobe coincides with the grant of the same requester: the old byte goes to txData_Out, the new byte is buffered with pending[i]=1, and overrun is not set.
- Winner selection (combinational): the first pending index searched from the pointer upward, wrapping modulo NUM_REQ.
- FSM, with STATE_SIZE=2 and state encodings IDLE=0, START=1, WAIT_ACK=2, WAIT_DONE=3:
  - IDLE, when any pending bit is set and txBusy=0, at the clock edge:
    - txData_Out <= holding[w] and grant <= onehot(w);
    - pending[w] <= 0 and pointer <= (w+1) mod NUM_REQ;
    - next state START.
  - IDLE with txBusy=1 (TX core busy externally): no grant; stay in IDLE.
  - START: txStart_Out=1 for exactly this one cycle (registered); next state WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK: if txBusy=1, go to WAIT_DONE. Otherwise the counter increments. When it reaches ACK_TIMEOUT-1 with txBusy still 0: timeout <= 1, go to IDLE.
  - WAIT_DONE: when txBusy=0, go to IDLE. No timeout applies here.
- Latency:
  - A strobe sampled at edge N sets pending at N.
  - The grant occurs at edge N+1, provided the FSM is in IDLE and txBusy=0.
  - txStart_Out is high between edges N+1 and N+2.
  - Back-to-back frames: after the edge that leaves WAIT_DONE, the next grant is one edge later.
- txData_Out and grant_Out hold their values from one grant until the next grant.
- clearFlags_InHigh=1 clears overrun and timeout at the edge. A flag-setting event in the same cycle takes priority, so the flag stays 1.
- Only bits [NUM_REQ-1:0] exist on the per-requester ports. The pointer never exceeds NUM_REQ-1.

Test Plan:
- Single request: reset, strobe newData=01 with byte0=0x41 → pending=01 after the edge. On the next edge: grant=01, txData=0x41, pending=00. txStart is high for exactly 1 cycle.
- Round-robin fairness, NUM_REQ=2: both requesters pending with 0x11 and 0x22, TX model asserts busy 2 cycles after start for 10 cycles → frames are sent 0x11 then 0x22. Re-arming both after that → 0x11 then 0x22 again, since the pointer has wrapped to 0.
- Overrun: requester 1 strobes 0x55 then 0x66 while the arbiter is in WAIT_DONE → 0x66 is transmitted and overrun=10. Pulsing clearFlags → overrun=00.
- Timeout: txBusy tied to 0 and one request issued → WAIT_ACK lasts ACK_TIMEOUT cycles, then timeout=1 and the FSM returns to IDLE. The next pending byte is still granted.
- Simultaneous strobe and grant: requester 0 pending with 0x01, new strobe 0x02 on the grant edge → txData=0x01, pending=01 with 0x02 buffered, overrun=00.
- Reset mid-frame: assert reset during WAIT_DONE with requester 1 pending → all outputs are 0 immediately, with no clock edge needed. After release, no start pulse occurs without a new strobe.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte producers.
// One byte is buffered per producer; a start pulse is issued, then the busy handshake is tracked.

module uart_tx_arbiter_slot #(
    parameter int DATAWIDTH_BUS = 8
) (
    input  logic                     SLOT_CLOCK_50,
    input  logic                     SLOT_RESET_InHigh,
    input  logic                     newData,
    input  logic [DATAWIDTH_BUS-1:0] data,
    input  logic                     grantHit,
    input  logic                     clearFlags,
    output logic [DATAWIDTH_BUS-1:0] holding,
    output logic                     pending,
    output logic                     overrun
);

    // A strobe on the grant edge re-arms the slot; the granted byte has already left.
    always_ff @(posedge SLOT_CLOCK_50 or posedge SLOT_RESET_InHigh) begin
        if (SLOT_RESET_InHigh) begin
            holding <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (newData) holding <= data;
            if (newData) pending <= 1'b1;
            else if (grantHit) pending <= 1'b0;
            if (newData && pending && !grantHit) overrun <= 1'b1;
            else if (clearFlags) overrun <= 1'b0;
        end
    end

endmodule

module uart_tx_arbiter #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_REQ       = 2,
    parameter int REQ_IDX_SIZE  = 3,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                             UART_TX_ARBITER_CLOCK_50,
    input  logic                             UART_TX_ARBITER_RESET_InHigh,
    input  logic [NUM_REQ-1:0]               UART_TX_ARBITER_newData_InHigh,
    input  logic [NUM_REQ*DATAWIDTH_BUS-1:0] UART_TX_ARBITER_data_In,
    input  logic                             UART_TX_ARBITER_txBusy_InHigh,
    input  logic                             UART_TX_ARBITER_clearFlags_InHigh,
    output logic                             UART_TX_ARBITER_txStart_Out,
    output logic [DATAWIDTH_BUS-1:0]         UART_TX_ARBITER_txData_Out,
    output logic [NUM_REQ-1:0]               UART_TX_ARBITER_grant_Out,
    output logic [NUM_REQ-1:0]               UART_TX_ARBITER_pending_Out,
    output logic [NUM_REQ-1:0]               UART_TX_ARBITER_overrun_Out,
    output logic                             UART_TX_ARBITER_timeout_Out
);

    localparam int STATE_SIZE = 2;
    localparam int CNT_SIZE   = $clog2(ACK_TIMEOUT);

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                                 state, stateNext;
    logic [REQ_IDX_SIZE-1:0]                pointer, winner;
    logic [NUM_REQ-1:0]                     winOnehot, grantHit;
    logic [DATAWIDTH_BUS-1:0]               winData;
    logic [NUM_REQ-1:0][DATAWIDTH_BUS-1:0]  holding;
    logic [CNT_SIZE-1:0]                    ackCount;
    logic                                   anyPending, grantFire, timeoutSet;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : genSlot
            uart_tx_arbiter_slot #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) slot (
                .SLOT_CLOCK_50     (UART_TX_ARBITER_CLOCK_50),
                .SLOT_RESET_InHigh (UART_TX_ARBITER_RESET_InHigh),
                .newData           (UART_TX_ARBITER_newData_InHigh[g]),
                .data              (UART_TX_ARBITER_data_In[g*DATAWIDTH_BUS +: DATAWIDTH_BUS]),
                .grantHit          (grantHit[g]),
                .clearFlags        (UART_TX_ARBITER_clearFlags_InHigh),
                .holding           (holding[g]),
                .pending           (UART_TX_ARBITER_pending_Out[g]),
                .overrun           (UART_TX_ARBITER_overrun_Out[g])
            );
        end
    endgenerate

    // Search outward from the pointer; offset k maps to index pointer+k, wrapped once.
    always_comb begin
        anyPending = 1'b0;
        winner     = '0;
        winOnehot  = '0;
        winData    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!anyPending && UART_TX_ARBITER_pending_Out[i] &&
                    ((int'(pointer) + k == i) || (int'(pointer) + k - NUM_REQ == i))) begin
                    anyPending   = 1'b1;
                    winner       = REQ_IDX_SIZE'(i);
                    winOnehot[i] = 1'b1;
                    winData      = holding[i];
                end
            end
        end
    end

    assign grantFire = (state == IDLE) && anyPending && !UART_TX_ARBITER_txBusy_InHigh;
    assign grantHit  = grantFire ? winOnehot : '0;

    always_comb begin
        stateNext  = state;
        timeoutSet = 1'b0;
        case (state)
            IDLE:      if (grantFire) stateNext = START;
            START:     stateNext = WAIT_ACK;
            WAIT_ACK: begin
                if (UART_TX_ARBITER_txBusy_InHigh) begin
                    stateNext = WAIT_DONE;
                end else if (ackCount == CNT_SIZE'(ACK_TIMEOUT - 1)) begin
                    stateNext  = IDLE;
                    timeoutSet = 1'b1;
                end
            end
            WAIT_DONE: if (!UART_TX_ARBITER_txBusy_InHigh) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge UART_TX_ARBITER_CLOCK_50 or posedge UART_TX_ARBITER_RESET_InHigh) begin
        if (UART_TX_ARBITER_RESET_InHigh) state <= IDLE;
        else                              state <= stateNext;
    end

    // txStart is registered off the grant, so it is high exactly while the FSM sits in START.
    always_ff @(posedge UART_TX_ARBITER_CLOCK_50 or posedge UART_TX_ARBITER_RESET_InHigh) begin
        if (UART_TX_ARBITER_RESET_InHigh) begin
            pointer                     <= '0;
            ackCount                    <= '0;
            UART_TX_ARBITER_txStart_Out <= 1'b0;
            UART_TX_ARBITER_txData_Out  <= '0;
            UART_TX_ARBITER_grant_Out   <= '0;
            UART_TX_ARBITER_timeout_Out <= 1'b0;
        end else begin
            UART_TX_ARBITER_txStart_Out <= grantFire;
            if (grantFire) begin
                UART_TX_ARBITER_txData_Out <= winData;
                UART_TX_ARBITER_grant_Out  <= winOnehot;
                pointer <= (winner == REQ_IDX_SIZE'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == START)         ackCount <= '0;
            else if (state == WAIT_ACK) ackCount <= ackCount + 1'b1;
            if (timeoutSet)                             UART_TX_ARBITER_timeout_Out <= 1'b1;
            else if (UART_TX_ARBITER_clearFlags_InHigh) UART_TX_ARBITER_timeout_Out <= 1'b0;
        end
    end

endmodule
